uartcommtx: RTL and testbench

Buffered 8N1 UART transmitter and host-to-PC serial output path of the CPU. It accepts bytes from the core over a strobe/ready handshake and queues them in a small FIFO. It serialises each byte LSB-first on `tx` at a fixed baud of `CLKS_PER_BIT` clocks per bit. Consecutive bytes go out back-to-back with no idle gap between frames.

---
 rtl/uartcommtx.sv | 145 ++++++++++++++
 tb/tb_uartcommtx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uartcommtx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of an LSB-first serialiser.
// Latency: start bit begins 1 clock after a byte enters an empty, idle path; frames are 10*CLKS_PER_BIT.
// Backpressure: ready drops when the FIFO holds FIFO_DEPTH bytes; send while not ready is dropped.
module uartcommtx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          send,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL      = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shifter;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    logic            push;
    logic            pop;
    logic            bit_end;
    logic            have_data;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign have_data  = (count != '0);
    assign ready      = (count != FULL);
    assign push       = send && ready;
    // The shifter is loaded from idle, or straight out of the stop bit so frames abut.
    assign pop        = have_data && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy       = (state != IDLE) || have_data;
    assign fifo_count = count;

    // Byte storage; stale entries after reset are harmless because the pointers restart.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: start, eight data bits LSB first, stop; tx is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        state   <= START;
                        tx      <= 1'b0;
                        shifter <= mem[rd_ptr];
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shifter[0];
                        shifter  <= shifter >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state   <= START;
                            tx      <= 1'b0;
                            shifter <= mem[rd_ptr];
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartcommtx.sv
// Bench for uartcommtx: random and directed byte streams compared cycle by cycle to a frame-timing model.
// Latency: model predicts start of each frame as max(accept+1, previous start + 10 bit times).
// Backpressure: model ready is "queued, not yet started" count below FIFO depth.
module tb_uartcommtx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uartcommtx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .send       (send),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Reference model: every accepted byte gets a frame start time; line state is derived from it.
    typedef struct {
        logic [7:0] b;
        int         st;
    } frame_t;

    frame_t q[$];
    int     ecyc = 0;
    int     last_start = -100000;
    logic   m_tx = 1'b1;
    logic   m_busy = 1'b0;
    logic   m_ready = 1'b1;
    int     m_count = 0;
    int     m_next = -1;
    int     m_bit = -1;
    int     m_phase = -1;
    bit     m_active = 1'b0;

    task automatic model_step();
        int st;
        ecyc++;
        if (rst) begin
            q.delete();
            last_start = -100000;
        end else if (send && m_ready) begin
            st = (ecyc + 1 > last_start + FRAME) ? ecyc + 1 : last_start + FRAME;
            q.push_back('{data_in, st});
            last_start = st;
        end
        while (q.size() != 0 && q[0].st + FRAME <= ecyc) void'(q.pop_front());
        m_tx = 1'b1; m_busy = 1'b0; m_count = 0; m_next = -1;
        m_active = 1'b0; m_bit = -1; m_phase = -1;
        foreach (q[i]) begin
            if (q[i].st > ecyc) begin
                m_count++;
                if (m_next < 0) m_next = q[i].st;
            end else begin
                m_active = 1'b1;
                m_phase  = ecyc - q[i].st;
                m_bit    = m_phase / CPB;
                if (m_bit == 0)      m_tx = 1'b0;
                else if (m_bit == 9) m_tx = 1'b1;
                else                 m_tx = q[i].b[m_bit-1];
            end
        end
        m_busy  = m_active || (m_count != 0);
        m_ready = (m_count != DEPTH);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    function automatic logic [5:0] expv();
        return {m_tx, m_busy, m_ready, 3'(m_count)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; send = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, busy, ready, fifo_count} !== 6'b101000) begin
            miscompares++;
            $display("FAIL reset_held got=%b want=%b", {tx, busy, ready, fifo_count}, 6'b101000);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx, busy, ready, fifo_count} !== 6'b101000) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=%b", {tx, busy, ready, fifo_count}, 6'b101000);
        end
    endtask

    task automatic test_single_byte();
        int busy_cycles = 0;
        data_in = 8'hA5; send = 1'b1;
        for (int c = 0; c < FRAME + 6; c++) begin
            @(negedge clk);
            send = 1'b0;
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
        end
        vectors++;
        if (busy_cycles != FRAME + 1) begin
            miscompares++;
            $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, FRAME + 1);
        end
    endtask

    task automatic test_burst();
        int busy_cycles = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                vectors++;
                if (ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_ready6 got=%b want=0", ready);
                end
            end
            data_in = 8'(i); send = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL burst cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
        end
        send = 1'b0;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL burst cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
        end
        vectors++;
        if (busy_cycles != 5 * FRAME + 1) begin
            miscompares++;
            $display("FAIL burst_busy_len got=%0d want=%0d", busy_cycles, 5 * FRAME + 1);
        end
    endtask

    task automatic test_full_pop();
        bit hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'($urandom); send = 1'b1;
            @(negedge clk);
        end
        send = 1'b0;
        for (int c = 0; c < 2 * FRAME && !hit; c++) begin
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL fullpop cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
            if (m_active && m_phase == FRAME - 1 && m_count == DEPTH) begin
                hit = 1'b1;
                data_in = 8'hEE; send = 1'b1;
            end
            @(negedge clk);
        end
        send = 1'b0;
        vectors++;
        if (!hit || fifo_count !== 3'd3 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpop_edge hit=%0d count=%0d ready=%b want count=3 ready=1", hit, fifo_count, ready);
        end
        for (int c = 0; c < 6 * FRAME && (busy !== 1'b0 || m_busy); c++) begin
            @(negedge clk);
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL fullpop cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
        end
    endtask

    task automatic test_push_pop();
        int  sent = 0;
        bit  pp = 1'b0;
        int  pp_seen = 0;
        for (int c = 0; c < 14 * FRAME; c++) begin
            @(negedge clk);
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL pushpop cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
            if (pp) begin
                pp_seen++;
                vectors++;
                if (fifo_count !== 3'd2) begin
                    miscompares++;
                    $display("FAIL pushpop_count got=%0d want=2", fifo_count);
                end
            end
            pp = 1'b0;
            send = 1'b0;
            if (sent < 10 && (m_count < 2 || (m_count == 2 && m_next == ecyc + 1))) begin
                pp = (m_count == 2);
                data_in = 8'($urandom); send = 1'b1;
                sent++;
            end
        end
        send = 1'b0;
        vectors++;
        if (sent != 10 || pp_seen < 5 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop_done sent=%0d pp=%0d busy=%b want 10,>=5,0", sent, pp_seen, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'($urandom); send = 1'b1;
            @(negedge clk);
        end
        send = 1'b0;
        for (int c = 0; c < FRAME && !hit; c++) begin
            if (m_active && m_bit == 4 && m_count == 2) begin
                hit = 1'b1;
                rst = 1'b1; send = 1'b1; data_in = 8'h77;
            end
            @(negedge clk);
        end
        vectors++;
        if (!hit || {tx, busy, ready, fifo_count} !== 6'b101000) begin
            miscompares++;
            $display("FAIL reset_mid hit=%0d got=%b want=101000", hit, {tx, busy, ready, fifo_count});
        end
        rst = 1'b0; send = 1'b0;
        repeat (3) @(negedge clk);
        data_in = 8'h3C; send = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge clk);
            send = 1'b0;
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL reset_mid_3c cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
        end
    endtask

    task automatic test_idle();
        rst = 1'b1; send = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle cyc=%0d tx=%b busy=%b want tx=1 busy=0", ecyc, tx, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600 || (c < 2000 && (busy !== 1'b0 || m_busy)); c++) begin
            @(negedge clk);
            vectors++;
            if ({tx, busy, ready, fifo_count} !== expv()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b want=%b", ecyc, {tx, busy, ready, fifo_count}, expv());
            end
            send = (c < 600) && ($urandom_range(0, 5) == 0);
            data_in = 8'($urandom);
        end
        send = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain busy=%b want=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_full_pop();
        test_push_pop();
        test_reset_mid();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
